// File: rtl/multi_ch_capture_pkg.sv
// Shared types for the multi-channel capture engine: FSM state encoding,
// capture mode constants and a small state decode helper.
package multi_ch_capture_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FILL      = 3'd1,
      PRE       = 3'd2,
      WAIT_TRIG = 3'd3,
      POST      = 3'd4,
      DONE      = 3'd5
   } cap_state_e;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_TRIG    = 1'b1;

   // True in every state that is actively writing capture memory.
   function automatic logic state_busy(cap_state_e s);
      return (s == FILL) || (s == PRE) || (s == WAIT_TRIG) || (s == POST);
   endfunction

endpackage

// File: rtl/multi_ch_capture_engine_ram.sv
// Simple dual-port capture memory: one write port, one read port with a
// registered output. The output register resets to zero; the array does not.
module capture_ram #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 1024,
   parameter int ADRS_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_reset,
   input  logic              i_we,
   input  logic [ADRS_W-1:0] i_wr_adrs,
   input  logic [WIDTH-1:0]  i_wr_data,
   input  logic              i_re,
   input  logic [ADRS_W-1:0] i_rd_adrs,
   output logic [WIDTH-1:0]  o_rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port.
   always_ff @(posedge clk) begin
      if (i_we) mem[i_wr_adrs] <= i_wr_data;
   end

   // Registered read port; holds its value when no read is issued.
   always_ff @(posedge clk) begin
      if (i_reset)   o_rd_data <= '0;
      else if (i_re) o_rd_data <= mem[i_rd_adrs];
   end

endmodule

// File: rtl/multi_ch_capture_engine.sv
// Multi-channel capture engine: logs one selected channel into a capture RAM
// with decimation, one-shot fill and circular pre/post-trigger modes.
// Results are read back over a registered read port while idle or done.
module multi_ch_capture_engine
   import multi_ch_capture_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int NBT_CH    = 12,
   parameter int RAM_WIDTH = 32,
   parameter int RAM_DEPTH = 1024,
   parameter int NBT_DEC   = 8,
   localparam int AW       = $clog2(RAM_DEPTH),
   localparam int CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     i_reset,
   input  logic [NUM_CH*NBT_CH-1:0] i_data,
   input  logic                     i_valid,
   input  logic [CW-1:0]            i_ch_sel,
   input  logic                     i_mode,
   input  logic [NBT_DEC-1:0]       i_dec,
   input  logic [AW-1:0]            i_pretrig,
   input  logic                     i_arm,
   input  logic                     i_trigger,
   input  logic                     i_rd_en,
   input  logic [AW-1:0]            i_rd_adrs,
   output logic [RAM_WIDTH-1:0]     o_rd_data,
   output logic                     o_rd_valid,
   output logic                     o_busy,
   output logic                     o_done,
   output logic [AW-1:0]            o_trig_adrs,
   output logic [AW:0]              o_wr_count
);

   localparam logic [AW:0]        DEPTH_W = (AW+1)'(RAM_DEPTH);
   localparam logic [AW:0]        CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0]      PRE_MAX = AW'(RAM_DEPTH - 1);
   localparam logic [NBT_DEC-1:0] DEC_ONE = NBT_DEC'(1);

   cap_state_e state, state_nx;

   logic [NUM_CH-1:0][NBT_CH-1:0] ch_data;
   logic signed [NBT_CH-1:0]      sel_smp;
   logic [RAM_WIDTH-1:0]          wr_data;

   logic [CW-1:0]      ch_sel_q;
   logic [NBT_DEC-1:0] dec_q, dec_cnt;
   logic [AW-1:0]      pretrig_q, pretrig_in, wr_ptr;
   logic [AW:0]        wr_count, post_cnt, post_tgt;
   logic               trig_latch;
   logic               qual, we, re, trig_hit;

   // Channel select and sign extension of the logged sample.
   assign ch_data = i_data;
   assign sel_smp = ch_data[ch_sel_q];
   assign wr_data = RAM_WIDTH'(sel_smp);

   // Pre-trigger count can never consume the whole buffer: at least the
   // trigger sample itself must fit behind it.
   assign pretrig_in = (i_pretrig >= PRE_MAX) ? PRE_MAX : i_pretrig;

   // A write happens on every valid sample that lands on decimation phase 0.
   // An arm or reset in the same cycle wins and suppresses the write.
   assign qual     = o_busy & i_valid & (dec_cnt == '0);
   assign we       = qual & ~i_arm & ~i_reset;
   assign trig_hit = (state == WAIT_TRIG) & qual & (i_trigger | trig_latch);
   assign post_tgt = DEPTH_W - {1'b0, pretrig_q};
   assign re       = i_rd_en & ~o_busy;

   assign o_wr_count = wr_count;

   // State register.
   always_ff @(posedge clk) begin
      if (i_reset) state <= IDLE;
      else         state <= state_nx;
   end

   // Next-state logic; arm restarts from any state and beats a trigger.
   always_comb begin
      state_nx = state;
      if (i_arm) begin
         if (i_mode == MODE_ONESHOT)  state_nx = FILL;
         else if (pretrig_in == '0)   state_nx = WAIT_TRIG;
         else                         state_nx = PRE;
      end else begin
         case (state)
            FILL:      if (qual && (wr_count == DEPTH_W - CNT_ONE))
                          state_nx = DONE;
            PRE:       if (qual && ((wr_count + CNT_ONE) == {1'b0, pretrig_q}))
                          state_nx = WAIT_TRIG;
            WAIT_TRIG: if (trig_hit)
                          state_nx = (post_tgt == CNT_ONE) ? DONE : POST;
            POST:      if (qual && ((post_cnt + CNT_ONE) == post_tgt))
                          state_nx = DONE;
            default:   ;
         endcase
      end
   end

   // Status outputs decoded from the state.
   always_comb begin
      o_busy = state_busy(state);
      o_done = (state == DONE);
   end

   // Capture datapath: config latch, decimation, pointer, counters, trigger.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         ch_sel_q    <= '0;
         dec_q       <= '0;
         pretrig_q   <= '0;
         dec_cnt     <= '0;
         wr_ptr      <= '0;
         wr_count    <= '0;
         post_cnt    <= '0;
         trig_latch  <= 1'b0;
         o_trig_adrs <= '0;
      end else if (i_arm) begin
         ch_sel_q    <= i_ch_sel;
         dec_q       <= i_dec;
         pretrig_q   <= pretrig_in;
         dec_cnt     <= '0;
         wr_ptr      <= '0;
         wr_count    <= '0;
         post_cnt    <= '0;
         trig_latch  <= 1'b0;
         o_trig_adrs <= '0;
      end else begin
         if (o_busy && i_valid)
            dec_cnt <= (dec_cnt == dec_q) ? '0 : dec_cnt + DEC_ONE;
         if (qual) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (wr_count != DEPTH_W) wr_count <= wr_count + CNT_ONE;
         end
         if (state == WAIT_TRIG) begin
            if (trig_hit) begin
               o_trig_adrs <= wr_ptr;
               post_cnt    <= CNT_ONE;
               trig_latch  <= 1'b0;
            end else if (i_trigger) begin
               trig_latch  <= 1'b1;
            end
         end
         if ((state == POST) && qual) post_cnt <= post_cnt + CNT_ONE;
      end
   end

   // Read strobe follows the request by one cycle, only when not capturing.
   always_ff @(posedge clk) begin
      if (i_reset) o_rd_valid <= 1'b0;
      else         o_rd_valid <= re;
   end

   capture_ram #(
      .WIDTH (RAM_WIDTH),
      .DEPTH (RAM_DEPTH),
      .ADRS_W(AW)
   ) u_ram (
      .clk      (clk),
      .i_reset  (i_reset),
      .i_we     (we),
      .i_wr_adrs(wr_ptr),
      .i_wr_data(wr_data),
      .i_re     (re),
      .i_rd_adrs(i_rd_adrs),
      .o_rd_data(o_rd_data)
   );

endmodule

// File: tb/tb_multi_ch_capture_engine.sv
// Bench for multi_ch_capture_engine: table of capture scenarios, table of
// read-back vectors checked through an expected-data queue, plus hand-written
// re-arm and reset-mid-capture sequences.
module tb_multi_ch_capture_engine;

   localparam int NUM_CH = 4, NBT_CH = 12, RAM_WIDTH = 32, RAM_DEPTH = 16, NBT_DEC = 8;

   logic                     clk;
   logic                     i_reset;
   logic [NUM_CH*NBT_CH-1:0] i_data;
   logic                     i_valid;
   logic [1:0]               i_ch_sel;
   logic                     i_mode;
   logic [NBT_DEC-1:0]       i_dec;
   logic [3:0]               i_pretrig;
   logic                     i_arm;
   logic                     i_trigger;
   logic                     i_rd_en;
   logic [3:0]               i_rd_adrs;
   logic [RAM_WIDTH-1:0]     o_rd_data;
   logic                     o_rd_valid;
   logic                     o_busy;
   logic                     o_done;
   logic [3:0]               o_trig_adrs;
   logic [4:0]               o_wr_count;

   multi_ch_capture_engine #(
      .NUM_CH(NUM_CH), .NBT_CH(NBT_CH), .RAM_WIDTH(RAM_WIDTH),
      .RAM_DEPTH(RAM_DEPTH), .NBT_DEC(NBT_DEC)
   ) dut (
      .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
      .i_ch_sel(i_ch_sel), .i_mode(i_mode), .i_dec(i_dec), .i_pretrig(i_pretrig),
      .i_arm(i_arm), .i_trigger(i_trigger), .i_rd_en(i_rd_en), .i_rd_adrs(i_rd_adrs),
      .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_busy(o_busy), .o_done(o_done),
      .o_trig_adrs(o_trig_adrs), .o_wr_count(o_wr_count)
   );

   typedef struct {
      int ch; int mode; int dec; int pre; int trig0; int trig1; int base;
      int exp_len; int exp_tadr; int exp_cnt;
   } cap_vec_t;

   typedef struct {
      int scn; int adrs; int exp;
   } rd_vec_t;

   cap_vec_t          cv[6];
   rd_vec_t           rv[$];
   logic [31:0]       exp_q[$];
   logic [31:0]       last_rd;
   int                n_chk = 0;
   int                n_fail = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Selected channel carries v; every other channel carries a distinct
   // negative filler so a wrong select or missing sign extension shows up.
   function automatic logic [NUM_CH*NBT_CH-1:0] pack(input int c, input int v);
      logic [NUM_CH-1:0][NBT_CH-1:0] d;
      for (int i = 0; i < NUM_CH; i++)
         d[i] = (i == c) ? v[11:0] : 12'hA50 + 12'(i);
      return d;
   endfunction

   // Read-data monitor: every o_rd_valid pops one expected word.
   always @(negedge clk) begin
      if (o_rd_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rd_unexpected: got rd_valid=1 with data 0x%0h, required no read", o_rd_data);
         end else begin
            last_rd = exp_q.pop_front();
            chk("rd_data", o_rd_data, last_rd);
         end
      end
   end

   // Arm with a config, then scramble the config inputs while capturing.
   task automatic arm(input int ch, input int mode, input int dec, input int pre);
      i_ch_sel  = 2'(ch);
      i_mode    = mode[0];
      i_dec     = 8'(dec);
      i_pretrig = 4'(pre);
      i_arm     = 1'b1;
      step();
      i_arm     = 1'b0;
      i_ch_sel  = 2'(ch + 1);
      i_mode    = ~mode[0];
      i_dec     = 8'(dec + 3);
      i_pretrig = 4'(pre + 5);
   endtask

   // Feed a ramp base+n on channel ch every cycle until the capture ends.
   task automatic run_capture(input int ch, input int base, input int t0, input int t1,
                              output int n);
      n = 0;
      while (o_busy === 1'b1 && n < 200) begin
         i_data    = pack(ch, base + n);
         i_valid   = 1'b1;
         i_trigger = (n == t0) || (n == t1);
         step();
         n++;
      end
      i_valid   = 1'b0;
      i_trigger = 1'b0;
   endtask

   task automatic do_reads(input int s);
      for (int i = 0; i < rv.size(); i++) begin
         if (rv[i].scn == s) begin
            i_rd_en   = 1'b1;
            i_rd_adrs = 4'(rv[i].adrs);
            exp_q.push_back(32'(rv[i].exp));
            step();
         end
      end
      i_rd_en = 1'b0;
      step();
      chk($sformatf("rd_valid_drop[%0d]", s), {31'd0, o_rd_valid}, 32'd0);
      chk($sformatf("rd_all_seen[%0d]", s), exp_q.size(), 32'd0);
   endtask

   initial begin
      int n;

      //          ch mode dec pre t0  t1  base len tadr cnt
      cv[0] = '{2, 0, 0, 0,  5, -1, -5, 16, 0, 16};
      cv[1] = '{0, 0, 2, 0, -1, -1,  0, 46, 0, 16};
      cv[2] = '{1, 1, 0, 4, 20, -1,  0, 32, 4, 16};
      cv[3] = '{0, 1, 1, 2,  1,  9,  0, 37, 5, 16};
      cv[4] = '{3, 1, 0, 0,  3, -1,  0, 19, 3, 16};
      cv[5] = '{1, 1, 0, 15, 20, -1, 0, 21, 4, 16};

      rv = '{'{0, 0, -5}, '{0, 15, 10}, '{0, 1, -4},
             '{1, 0, 0}, '{1, 1, 3}, '{1, 7, 21}, '{1, 15, 45},
             '{2, 0, 16}, '{2, 4, 20}, '{2, 3, 19}, '{2, 15, 31},
             '{3, 5, 10}, '{3, 3, 6}, '{3, 2, 36}, '{3, 0, 32},
             '{4, 3, 3}, '{4, 2, 18},
             '{5, 4, 20}, '{5, 5, 5}, '{5, 3, 19},
             '{10, 0, 300}, '{10, 9, 309}, '{10, 15, 315},
             '{11, 6, 6}, '{11, 8, 8}, '{11, 9, 309}, '{11, 10, 310}};

      i_reset = 1'b1; i_data = '0; i_valid = 1'b0; i_ch_sel = '0; i_mode = 1'b0;
      i_dec = '0; i_pretrig = '0; i_arm = 1'b0; i_trigger = 1'b0;
      i_rd_en = 1'b0; i_rd_adrs = '0; last_rd = '0;
      repeat (3) step();
      i_reset = 1'b0;
      step();
      chk("rst_busy",  {31'd0, o_busy}, 32'd0);
      chk("rst_done",  {31'd0, o_done}, 32'd0);
      chk("rst_tadr",  {28'd0, o_trig_adrs}, 32'd0);
      chk("rst_cnt",   {27'd0, o_wr_count}, 32'd0);
      chk("rst_rdv",   {31'd0, o_rd_valid}, 32'd0);
      chk("rst_rdata", o_rd_data, 32'd0);

      for (int s = 0; s < 6; s++) begin
         arm(cv[s].ch, cv[s].mode, cv[s].dec, cv[s].pre);
         chk($sformatf("s%0d_busy_armed", s), {31'd0, o_busy}, 32'd1);
         chk($sformatf("s%0d_cnt_armed", s), {27'd0, o_wr_count}, 32'd0);
         run_capture(cv[s].ch, cv[s].base, cv[s].trig0, cv[s].trig1, n);
         chk($sformatf("s%0d_len", s),  n, cv[s].exp_len);
         chk($sformatf("s%0d_done", s), {31'd0, o_done}, 32'd1);
         chk($sformatf("s%0d_tadr", s), {28'd0, o_trig_adrs}, cv[s].exp_tadr);
         chk($sformatf("s%0d_cnt", s),  {27'd0, o_wr_count}, cv[s].exp_cnt);
         do_reads(s);
      end

      // Re-arm mid-capture with a different channel.
      arm(2, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         i_data = pack(2, 100 + k); i_valid = 1'b1; step();
      end
      i_valid = 1'b0;
      chk("rearm_cnt_before", {27'd0, o_wr_count}, 32'd5);
      arm(3, 0, 0, 0);
      chk("rearm_cnt_after", {27'd0, o_wr_count}, 32'd0);
      chk("rearm_busy", {31'd0, o_busy}, 32'd1);
      i_rd_en = 1'b1; i_rd_adrs = 4'd0;
      step();
      i_rd_en = 1'b0;
      chk("busy_rd_valid", {31'd0, o_rd_valid}, 32'd0);
      chk("busy_rd_held", o_rd_data, 32'd19);
      run_capture(3, 300, -1, -1, n);
      chk("rearm_len", n, 32'd16);
      chk("rearm_done", {31'd0, o_done}, 32'd1);
      do_reads(10);

      // Reset while in POST.
      arm(1, 1, 0, 4);
      for (int k = 0; k < 9; k++) begin
         i_data = pack(1, k); i_valid = 1'b1; i_trigger = (k == 6); step();
      end
      i_trigger = 1'b0;
      chk("post_busy", {31'd0, o_busy}, 32'd1);
      chk("post_tadr", {28'd0, o_trig_adrs}, 32'd6);
      chk("post_cnt",  {27'd0, o_wr_count}, 32'd9);
      i_data = pack(1, 9); i_valid = 1'b1; i_reset = 1'b1;
      step();
      chk("mid_rst_busy",  {31'd0, o_busy}, 32'd0);
      chk("mid_rst_done",  {31'd0, o_done}, 32'd0);
      chk("mid_rst_tadr",  {28'd0, o_trig_adrs}, 32'd0);
      chk("mid_rst_cnt",   {27'd0, o_wr_count}, 32'd0);
      chk("mid_rst_rdv",   {31'd0, o_rd_valid}, 32'd0);
      chk("mid_rst_rdata", o_rd_data, 32'd0);
      i_reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         i_data = pack(1, 999); i_valid = 1'b1; step();
      end
      i_valid = 1'b0;
      chk("idle_busy", {31'd0, o_busy}, 32'd0);
      chk("idle_cnt",  {27'd0, o_wr_count}, 32'd0);
      do_reads(11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
